// File: rtl/count_ctrl_if.sv
// ----------------------------------------------------------------------------
// count_ctrl_if
// Bundles the control, adder-feedback and status signals of count_ctrl.
//
// Control protocol: start, stop and load are plain levels sampled on every
// rising clock edge. There is no valid/ready handshake. load beats start/stop
// in the same cycle. stop beats start. sum_in is the combinational adder
// result for the current cnt, and count_ctrl may capture it on any edge.
//
// Signals:
//   start     begin/resume counting (level)
//   stop      pause counting (level)
//   load      synchronous load of load_val into cnt
//   load_val  value written by load
//   sum_in    adder result (cnt + step), bit WIDTH is carry-out
//   cnt       current count, drives the adder A1 operand
//   busy      high while RUN or HOLD
//   done      one-cycle pulse when the terminal count is reached
//   ovf       sticky overflow flag
//
// Modports:
//   master  side that drives control and adder feedback (testbench, parent)
//   slave   count_ctrl itself
// ----------------------------------------------------------------------------
interface count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, stop, load, load_val, sum_in,
        input  cnt, busy, done, ovf
    );

    modport slave (
        input  start, stop, load, load_val, sum_in,
        output cnt, busy, done, ovf
    );
endinterface

// File: rtl/count_ctrl.sv
// ----------------------------------------------------------------------------
// count_ctrl
// Register and control stage that sits directly in front of the 4-bit adder
// in the counter datapath. It holds the count and drives it to the adder. While
// running, it captures the adder sum back on each edge. It also provides
// start/stop/load control, terminal-count detection, a done pulse and a sticky
// overflow flag.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   bus        count_ctrl_if.slave (start, stop, load, load_val, sum_in in;
//              cnt, busy, done, ovf out)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 HOLD, 3 DONE)
// ----------------------------------------------------------------------------
module count_ctrl #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] LIMIT        = 4'd9,
    parameter bit               AUTO_RESTART = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    count_ctrl_if.slave  bus,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_q, cnt_nxt;
    logic             done_q, done_nxt;
    logic             ovf_q, ovf_nxt;

    // Starting or resuming requires start without stop, because stop wins.
    logic go;
    assign go = bus.start && !bus.stop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt_q  <= cnt_nxt;
            done_q <= done_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        ovf_nxt   = ovf_q;

        if (bus.load) begin
            // load overrides start/stop. It only leaves DONE, which is an
            // end state, and returns to IDLE. RUN and HOLD are kept.
            cnt_nxt = bus.load_val;
            ovf_nxt = 1'b0;
            if (state == DONE) begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = HOLD;
                    end else if (cnt_q == LIMIT) begin
                        // If LIMIT is 0 with auto-restart, cnt is still at
                        // LIMIT on the cycle while done is high. In that case
                        // this cycle is idle, so done only pulses every other
                        // cycle.
                        if (!done_q) begin
                            done_nxt = 1'b1;
                            cnt_nxt  = '0;
                            if (AUTO_RESTART) begin
                                state_nxt = RUN;
                            end else begin
                                state_nxt = DONE;
                            end
                        end
                    end else if (bus.sum_in[WIDTH]) begin
                        ovf_nxt = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = bus.sum_in[WIDTH-1:0];
                    end
                end
                HOLD: begin
                    if (go) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    cnt_nxt = '0;
                    if (go) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.cnt   = cnt_q;
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = (state == RUN) || (state == HOLD);
    assign state_dbg = state;

endmodule

// File: tb/tb_count_ctrl.sv
// ----------------------------------------------------------------------------
// tb_count_ctrl
// Drives three count_ctrl instances:
//   dut_a  LIMIT=9, AUTO_RESTART=0
//   dut_b  LIMIT=2, AUTO_RESTART=1
//   dut_c  LIMIT=0, AUTO_RESTART=1
// Each sum_in is modelled as cnt + 1, which acts as the downstream adder.
// The driver pushes the output snapshot expected after each edge. A monitor
// per DUT pops that snapshot and compares it one time unit after the edge.
// ----------------------------------------------------------------------------
module tb_count_ctrl;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_R = 2'd1;
    localparam logic [1:0] S_H = 2'd2;
    localparam logic [1:0] S_D = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    count_ctrl_if #(.WIDTH(4)) bus_a ();
    count_ctrl_if #(.WIDTH(4)) bus_b ();
    count_ctrl_if #(.WIDTH(4)) bus_c ();
    logic [1:0] st_a, st_b, st_c;

    // Adder model: sum = cnt + 1 with carry-out in bit 4.
    assign bus_a.sum_in = {1'b0, bus_a.cnt} + 5'd1;
    assign bus_b.sum_in = {1'b0, bus_b.cnt} + 5'd1;
    assign bus_c.sum_in = {1'b0, bus_c.cnt} + 5'd1;

    count_ctrl #(.WIDTH(4), .LIMIT(4'd9), .AUTO_RESTART(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave), .state_dbg(st_a));
    count_ctrl #(.WIDTH(4), .LIMIT(4'd2), .AUTO_RESTART(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave), .state_dbg(st_b));
    count_ctrl #(.WIDTH(4), .LIMIT(4'd0), .AUTO_RESTART(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c.slave), .state_dbg(st_c));

    // ---------------- scoreboard ----------------
    // Snapshot layout: {state[1:0], cnt[3:0], busy, done, ovf}
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [8:0] exp_c[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [8:0] ex(logic [1:0] s, logic [3:0] c,
                                      logic b, logic d, logic o);
        return {s, c, b, d, o};
    endfunction

    function automatic logic [8:0] act_of(int d);
        case (d)
            0:       return {st_a, bus_a.cnt, bus_a.busy, bus_a.done, bus_a.ovf};
            1:       return {st_b, bus_b.cnt, bus_b.busy, bus_b.done, bus_b.ovf};
            default: return {st_c, bus_c.cnt, bus_c.busy, bus_c.done, bus_c.ovf};
        endcase
    endfunction

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] want);
        n_total++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got st=%0d cnt=%0d busy=%b done=%b ovf=%b, expected st=%0d cnt=%0d busy=%b done=%b ovf=%b",
                     name, $time, act[8:7], act[6:3], act[2], act[1], act[0],
                     want[8:7], want[6:3], want[2], want[1], want[0]);
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        #1;
        if (exp_a.size() != 0) check("dut_a", act_of(0), exp_a.pop_front());
    end
    always @(posedge clk) begin
        #1;
        if (exp_b.size() != 0) check("dut_b", act_of(1), exp_b.pop_front());
    end
    always @(posedge clk) begin
        #1;
        if (exp_c.size() != 0) check("dut_c", act_of(2), exp_c.pop_front());
    end

    // ---------------- driver ----------------
    // Called at a falling edge. Applies inputs for the next rising edge and
    // queues the outputs expected after it.
    task automatic drv(input int d, input logic st, input logic sp,
                       input logic ld, input logic [3:0] lv,
                       input logic [8:0] e);
        case (d)
            0: begin
                bus_a.start = st; bus_a.stop = sp; bus_a.load = ld; bus_a.load_val = lv;
                exp_a.push_back(e);
            end
            1: begin
                bus_b.start = st; bus_b.stop = sp; bus_b.load = ld; bus_b.load_val = lv;
                exp_b.push_back(e);
            end
            default: begin
                bus_c.start = st; bus_c.stop = sp; bus_c.load = ld; bus_c.load_val = lv;
                exp_c.push_back(e);
            end
        endcase
        @(negedge clk);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.load = 1'b0; bus_a.load_val = 4'd0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.load = 1'b0; bus_b.load_val = 4'd0;
        bus_c.start = 1'b0; bus_c.stop = 1'b0; bus_c.load = 1'b0; bus_c.load_val = 4'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", act_of(0), ex(S_I, 4'd0, 1'b0, 1'b0, 1'b0));
        check("reset_b", act_of(1), ex(S_I, 4'd0, 1'b0, 1'b0, 1'b0));
        check("reset_c", act_of(2), ex(S_I, 4'd0, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        @(negedge clk);

        // Count 0..9, then done and DONE.
        drv(0, 1, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 0));
        for (int i = 1; i <= 9; i++) drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'(i), 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_D, 4'd0, 0, 1, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_D, 4'd0, 0, 0, 0));

        // Restart from DONE, pause at 4 for 3 cycles, then resume.
        drv(0, 1, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 0));
        for (int i = 1; i <= 4; i++) drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'(i), 1, 0, 0));
        repeat (3) drv(0, 0, 1, 0, 4'd0, ex(S_H, 4'd4, 1, 0, 0));
        drv(0, 1, 0, 0, 4'd0, ex(S_R, 4'd4, 1, 0, 0));
        for (int i = 5; i <= 9; i++) drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'(i), 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_D, 4'd0, 0, 1, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_D, 4'd0, 0, 0, 0));

        // Load 13 in HOLD, wrap through carry (ovf), then count to 9.
        drv(0, 1, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'd1, 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'd2, 1, 0, 0));
        drv(0, 0, 1, 0, 4'd0, ex(S_H, 4'd2, 1, 0, 0));
        drv(0, 0, 0, 1, 4'd13, ex(S_H, 4'd13, 1, 0, 0));
        drv(0, 1, 0, 0, 4'd0, ex(S_R, 4'd13, 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'd14, 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'd15, 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 1));
        for (int i = 1; i <= 9; i++) drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'(i), 1, 0, 1));
        drv(0, 0, 0, 0, 4'd0, ex(S_D, 4'd0, 0, 1, 1));
        drv(0, 0, 0, 0, 4'd0, ex(S_D, 4'd0, 0, 0, 1));

        // Load in DONE goes to IDLE and clears ovf. Then start+stop together.
        drv(0, 0, 0, 1, 4'd2, ex(S_I, 4'd2, 0, 0, 0));
        drv(0, 1, 1, 0, 4'd0, ex(S_I, 4'd2, 0, 0, 0));
        drv(0, 1, 0, 0, 4'd0, ex(S_R, 4'd2, 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'd3, 1, 0, 0));
        drv(0, 1, 1, 0, 4'd0, ex(S_H, 4'd3, 1, 0, 0));
        drv(0, 0, 1, 0, 4'd0, ex(S_H, 4'd3, 1, 0, 0));
        // load with start in the same cycle: start is ignored, HOLD kept.
        drv(0, 1, 0, 1, 4'd7, ex(S_H, 4'd7, 1, 0, 0));
        drv(0, 1, 0, 0, 4'd0, ex(S_R, 4'd7, 1, 0, 0));
        // load in RUN keeps RUN. Wrap to set ovf, then run up to 6.
        drv(0, 0, 0, 1, 4'd14, ex(S_R, 4'd14, 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'd15, 1, 0, 0));
        drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 1));
        for (int i = 1; i <= 6; i++) drv(0, 0, 0, 0, 4'd0, ex(S_R, 4'(i), 1, 0, 1));

        // Asynchronous reset in the middle of the cycle while cnt=6.
        #2 reset = 1'b0;
        #1 check("async_reset_a", act_of(0), ex(S_I, 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Auto-restart with LIMIT=2: done after each 2, busy stays high.
        drv(1, 1, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 0));
        drv(1, 0, 0, 0, 4'd0, ex(S_R, 4'd1, 1, 0, 0));
        drv(1, 0, 0, 0, 4'd0, ex(S_R, 4'd2, 1, 0, 0));
        drv(1, 0, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 1, 0));
        drv(1, 0, 0, 0, 4'd0, ex(S_R, 4'd1, 1, 0, 0));
        drv(1, 0, 0, 0, 4'd0, ex(S_R, 4'd2, 1, 0, 0));
        drv(1, 0, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 1, 0));
        drv(1, 0, 0, 0, 4'd0, ex(S_R, 4'd1, 1, 0, 0));

        // Auto-restart with LIMIT=0: done pulses every other cycle.
        drv(2, 1, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 0));
        drv(2, 0, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 1, 0));
        drv(2, 0, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 0));
        drv(2, 0, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 1, 0));
        drv(2, 0, 0, 0, 4'd0, ex(S_R, 4'd0, 1, 0, 0));
        drv(2, 0, 1, 0, 4'd0, ex(S_H, 4'd0, 1, 0, 0));

        repeat (2) @(negedge clk);
        check("drain_a", 9'(exp_a.size()), 9'd0);
        check("drain_b", 9'(exp_b.size()), 9'd0);
        check("drain_c", 9'(exp_c.size()), 9'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
